key_led_ctrl: RTL and testbench

Key-event controller that sits between the debounced key edge detector and the board LEDs. It consumes the single-cycle `pos_edge`/`neg_edge` strobes and classifies each key press as short or long by timing press duration. It then sequences a 2-bit LED output through four display modes.

---
 rtl/key_led_ctrl_if.sv | 12 +
 rtl/key_led_ctrl.sv | 104 ++++++++++
 tb/tb_key_led_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/key_led_ctrl_if.sv
// Key strobe inputs and LED/mode/pulse outputs of the key LED controller.
interface key_led_ctrl_if;
  logic       pos_edge;
  logic       neg_edge;
  logic [1:0] led;
  logic [1:0] mode;
  logic       short_pulse;
  logic       long_pulse;

  modport master (output pos_edge, neg_edge, input led, mode, short_pulse, long_pulse);
  modport slave  (input pos_edge, neg_edge, output led, mode, short_pulse, long_pulse);
endinterface

// File: rtl/key_led_ctrl.sv
// Classifies key presses as short/long and sequences a 2-bit LED through
// OFF / STATIC / BLINK / RUN display modes.
module key_led_ctrl #(
  parameter int LONG_CYC   = 50_000_000,
  parameter int BLINK_HALF = 12_500_000
) (
  input  logic           clk,
  input  logic           rst,
  key_led_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, PRESSED, LONG_HELD} state_t;

  // cnt is 0 right after the press edge, so the long threshold is reached on
  // the (LONG_CYC-1)th edge after the press.
  localparam logic [31:0] LONG_LAST  = 32'(LONG_CYC - 2);
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_HALF - 1);

  state_t      state, state_n;
  logic [31:0] cnt, cnt_n;
  logic [31:0] tmr;
  logic [1:0]  led_q, mode_q;
  logic        short_q, long_q, short_n, long_n;
  logic        pos_only, neg_only;

  assign pos_only = bus.pos_edge & ~bus.neg_edge;
  assign neg_only = bus.neg_edge & ~bus.pos_edge;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      short_q <= short_n;
      long_q  <= long_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    short_n = 1'b0;
    long_n  = 1'b0;
    unique case (state)
      IDLE: if (neg_only) begin
        state_n = PRESSED;
        cnt_n   = '0;
      end
      PRESSED: begin
        if (pos_only) begin
          state_n = IDLE;
          short_n = 1'b1;
        end else if (cnt == LONG_LAST) begin
          state_n = LONG_HELD;
          long_n  = 1'b1;
        end else begin
          cnt_n = cnt + 32'd1;
        end
      end
      LONG_HELD: if (pos_only) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Mode/LED react on the classification edge so the new pattern shows
  // alongside the pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= 2'd0;
      led_q  <= 2'b00;
      tmr    <= '0;
    end else if (short_n || long_n) begin
      tmr <= '0;
      if (long_n) begin
        mode_q <= 2'd0;
        led_q  <= 2'b00;
      end else begin
        mode_q <= mode_q + 2'd1;
        unique case (mode_q + 2'd1)
          2'd0:    led_q <= 2'b00;
          2'd3:    led_q <= 2'b01;
          default: led_q <= 2'b11;
        endcase
      end
    end else if (mode_q[1]) begin
      if (tmr == BLINK_LAST) begin
        tmr   <= '0;
        led_q <= ~led_q;
      end else begin
        tmr <= tmr + 32'd1;
      end
    end else begin
      tmr <= '0;
    end
  end

  assign bus.led         = led_q;
  assign bus.mode        = mode_q;
  assign bus.short_pulse = short_q;
  assign bus.long_pulse  = long_q;
endmodule

// File: tb/tb_key_led_ctrl.sv
// Directed plus randomized check of key_led_ctrl against a press-age /
// time-since-mode-entry reference model.
module tb_key_led_ctrl;
  localparam int LONG_CYC   = 8;
  localparam int BLINK_HALF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  key_led_ctrl_if bus ();

  key_led_ctrl #(.LONG_CYC(LONG_CYC), .BLINK_HALF(BLINK_HALF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  bit       in_press = 0, held_long = 0;
  int       age = 0, since = 0;
  int       m_mode = 0;
  bit       e_short = 0, e_long = 0;
  logic [1:0] e_led;

  function automatic logic [1:0] led_for(int md, int t);
    bit second_half;
    second_half = ((t / BLINK_HALF) % 2) == 1;
    case (md)
      0: return 2'b00;
      1: return 2'b11;
      2: return second_half ? 2'b00 : 2'b11;
      default: return second_half ? 2'b10 : 2'b01;
    endcase
  endfunction

  task automatic model(input bit p, input bit n, input bit r);
    bit po, no;
    po = p && !n;
    no = n && !p;
    e_short = 0;
    e_long  = 0;
    if (r) begin
      in_press = 0; held_long = 0; age = 0; m_mode = 0; since = 0;
    end else begin
      if (!in_press) begin
        if (no) begin
          in_press = 1; held_long = 0; age = 0;
        end
      end else begin
        age++;
        if (po) begin
          if (!held_long) e_short = 1;
          in_press = 0;
        end else if (!held_long && age == LONG_CYC - 1) begin
          e_long = 1;
          held_long = 1;
        end
      end
      if (e_short) begin
        m_mode = (m_mode + 1) % 4; since = 0;
      end else if (e_long) begin
        m_mode = 0; since = 0;
      end else begin
        since++;
      end
    end
    e_led = led_for(m_mode, since);
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input bit p, input bit n, input bit r = 0);
    bus.pos_edge = p;
    bus.neg_edge = n;
    rst = r;
    @(posedge clk);
    model(p, n, r);
    #1;
    chk("led",   bus.led, e_led);
    chk("mode",  bus.mode, 2'(m_mode));
    chk("short", {1'b0, bus.short_pulse}, {1'b0, e_short});
    chk("long",  {1'b0, bus.long_pulse}, {1'b0, e_long});
    assert (!(bus.short_pulse && bus.long_pulse)) else begin
      errors++;
      $error("FAIL both_pulses observed=11 expected=not both");
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  // neg_edge at edge k, pos_edge at edge k+hold
  task automatic press(input int hold);
    step(0, 1);
    idle(hold - 1);
    step(1, 0);
  endtask

  initial begin
    bus.pos_edge = 0;
    bus.neg_edge = 0;
    // reset with random strobes
    for (int i = 0; i < 2; i++) step(1'($urandom), 1'($urandom), 1);
    step(1, 0);
    idle(3);
    // short press: held 3 edges -> mode 1
    press(3);
    idle(5);
    // cycle modes 2, 3, 0 and watch blink/run patterns
    for (int i = 0; i < 3; i++) begin
      press($urandom_range(1, 6));
      idle($urandom_range(10, 14));
    end
    // reach mode 2 then long press; release at k+20
    press(2); idle(3);
    press(2); idle(6);
    step(0, 1);
    idle(19);
    step(1, 0);
    idle(4);
    // release on the long-threshold edge -> short only
    press(LONG_CYC - 1);
    idle(3);
    press(LONG_CYC - 2);
    idle(3);
    // simultaneous strobes in IDLE and in PRESSED, extra neg_edge at k+3
    step(1, 1);
    step(0, 1);
    step(1, 1);
    idle(1);
    step(0, 1);
    idle(12);
    step(1, 0);
    idle(3);
    // mode 2, PRESSED, then reset
    press(1); idle(2);
    press(1); idle(2);
    step(0, 1);
    idle(2);
    step(0, 0, 1);
    step(1, 0);
    idle(2);
    press(LONG_CYC + 2);
    idle(3);
    press(2);
    idle(6);
    // random soak
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 8 || r == 50, (r >= 8 && r < 14) || r == 50, r == 99);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
